// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter for a shared FIFO push port; multi-beat packets hold the grant until their last beat.
// Purely combinational datapath: the handshake, push and data all happen in the same cycle.
//
// state  | meaning
// IDLE   | arbitrating; candidate is the first valid requester at or after rr_ptr_q
// LOCKED | a packet is in flight; owner_q keeps the grant until its last beat transfers
module fifo_push_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 64,
    parameter int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_push,
    output logic [WIDTH-1:0]      fifo_din,
    input  logic                  fifo_full,
    output logic [IW-1:0]         grant_id,
    output logic                  locked
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_t;

    lock_t           lock_q, lock_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   search_cand;
    logic [IW-1:0]   cand;
    logic            cand_last;
    logic            xfer;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Rotate the valids so bit 0 is the pointer position, then take the nearest set bit.
    always_comb begin
        logic [2*NREQ-1:0] rot;
        logic [IW-1:0]     off;
        logic [IW:0]       sum;
        rot = {req_valid, req_valid} >> rr_ptr_q;
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        sum = {1'b0, rr_ptr_q} + {1'b0, off};
        if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
        search_cand = sum[IW-1:0];
    end

    assign cand = (lock_q == LOCKED) ? owner_q : search_cand;

    always_comb begin
        fifo_din  = '0;
        cand_last = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cand == IW'(i)) begin
                fifo_din     = req_data[i*WIDTH +: WIDTH];
                cand_last    = req_last[i];
                req_ready[i] = !rst && !fifo_full && ((lock_q == LOCKED) || req_valid[i]);
            end
        end
    end

    assign xfer      = |(req_valid & req_ready);
    assign fifo_push = xfer;
    assign grant_id  = rst ? '0 : cand;
    assign locked    = (lock_q == LOCKED);

    always_comb begin
        lock_d   = lock_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (lock_q)
            IDLE: begin
                if (xfer) begin
                    if (cand_last) begin
                        rr_ptr_d = wrap_inc(cand);
                    end else begin
                        lock_d  = LOCKED;
                        owner_d = cand;
                    end
                end
            end
            LOCKED: begin
                if (xfer && cand_last) begin
                    lock_d   = IDLE;
                    rr_ptr_d = wrap_inc(owner_q);
                end
            end
            default: lock_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q   <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter that shares the push port of one synchronous FIFO between NREQ producers using valid/ready handshakes. Supports multi-beat packets: once a requester's first beat is accepted without `req_last`, the grant is locked to it until its `req_last` beat is accepted. It sits directly in front of the FIFO's push/din/full pins and adds no latency or storage.

## Interface
- `NREQ`, default 4: number of requesters; ≥2, not required to be a power of two.
- `WIDTH`, default 64: data width in bits; matches the FIFO `WIDTH`.
- `IW`, derived as `$clog2(NREQ)`: width of the grant index.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester beat valid.
- `req_data`  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- `req_last`  in  NREQ  final beat of the packet; single-beat packets set it on their only beat.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `fifo_push`  out  1  push strobe to the FIFO.
- `fifo_din`  out  WIDTH  data to the FIFO.
- `fifo_full`  in  1  FIFO full flag.
- `grant_id`  out  IW  index of the current grant holder or candidate.
- `locked`  out  1  high while a multi-beat packet holds the grant.

## Operation
- State: `lock_q` (IDLE=0 / LOCKED=1), `owner_q` [IW], `rr_ptr_q` [IW].
- IDLE candidate: the first i with `req_valid[i]` searching `rr_ptr_q`, `rr_ptr_q+1`, … modulo NREQ. If no valid, candidate = `rr_ptr_q` and no transfer occurs.
- LOCKED candidate: `owner_q` regardless of other valids.
- `grant_id` = candidate. `fifo_din` = `req_data` slice of the candidate.
- `req_ready[i]` = (i == candidate) && !`fifo_full` && (LOCKED || `req_valid[i]`).
- Transfer `xfer` = `req_valid[cand]` && `req_ready[cand]`. `fifo_push` = `xfer`. No push ever occurs while `fifo_full`=1.
- Transitions:
  - IDLE, `xfer` && !last: go to LOCKED; `owner_q` ← cand.
  - IDLE, `xfer` && last: stay IDLE; `rr_ptr_q` ← (cand+1) mod NREQ.
  - LOCKED, `xfer` && last: go to IDLE; `rr_ptr_q` ← (`owner_q`+1) mod NREQ.
  - LOCKED, no xfer or !last: hold. The owner may drop valid mid-packet; other requesters wait.
  - No transfer: no state change.
- `rr_ptr_q` advances only on packet completion. Wrap from NREQ-1 to 0 is explicit, including for non-power-of-two NREQ.
- `locked` = `lock_q`.
- Producer rule, checked by the bench: once valid is asserted, data and last hold until ready.
- `req_last` on a non-candidate requester is ignored.

## Timing
- Reset values: `lock_q`=0, `owner_q`=0, `rr_ptr_q`=0.
- Output values while `rst` is asserted: `locked`=0, `grant_id`=0, `fifo_push`=0, all `req_ready`=0 regardless of inputs.
- Zero-cycle latency: `req_valid` → `req_ready`/`fifo_push`/`fifo_din` is combinational. The FIFO captures data on the same edge that the requester sees its handshake.
- State and pointer updates take effect on the edge ending the transfer cycle. The next beat, or the next packet's arbitration, uses the new state.
- `fifo_full` deasserting in cycle N allows a transfer in cycle N; there is no extra bubble.
- Reset mid-packet: the lock is dropped and the pointer returns to 0. The partial packet already in the FIFO is the system's concern; the FIFO is reset by the same `rst`.
- Sustained throughput: one beat per cycle while the candidate is valid and the FIFO is not full.

## Test plan
- After reset, no valids -> `fifo_push`=0, `req_ready`=0, `grant_id`=0, `locked`=0. Then `req_valid`=4'b0100 single-beat -> same-cycle push of req 2 data, `rr_ptr`→3.
- All 4 valid, single-beat packets every cycle for 8 cycles -> grants 0,1,2,3,0,1,2,3, one push per cycle, `fifo_din` matches each source.
- Req 1 sends a 3-beat packet while reqs 0, 2 and 3 stay valid -> grants 1,1,1 with `locked`=1 for beats 1–2. Next grant is 2. Req 1 drops valid for 2 cycles mid-packet -> no pushes and no grant to others.
- `fifo_full`=1 for 3 cycles with all reqs valid -> `req_ready`=0 and `fifo_push`=0 throughout; state unchanged. On deassert, the same candidate transfers that cycle.
- NREQ=3 build, reqs 2 and 0 valid, `rr_ptr`=2 -> req 2 granted, pointer wraps to 0, then req 0 granted.
- `rst` pulsed while LOCKED on req 3 -> `locked`=0 and `grant_id`=0 immediately. Afterwards req 0 wins over req 3 when both are valid.
